// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared codes and defaults for the instruction-fetch unit
package ifu_fetch_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   // Next-PC select codes driven by the controller
   typedef enum logic [1:0] {
      NPC_PC4 = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

   // Prefetch state machine
   typedef enum logic [1:0] {
      F_ISSUE = 2'b00,
      F_WAIT  = 2'b01,
      F_FLUSH = 2'b10,
      F_VALID = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - controller and instruction-memory signals of the fetch unit
interface ifu_fetch_if #(parameter int AW = 32);

   logic          PCWr;
   logic          IRWr;
   logic [1:0]    NPCOp;
   logic [31:0]   rs_data;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic [AW-1:0] pc;
   logic [31:0]   ir;
   logic [5:0]    op;
   logic [5:0]    funct;
   logic          if_stall;
   logic          pc_misalign;

   // Fetch unit side
   modport slave (
      input  PCWr, IRWr, NPCOp, rs_data, imem_ack, imem_rdata,
      output imem_req, imem_addr, pc, ir, op, funct, if_stall, pc_misalign
   );

   // Controller / memory side
   modport master (
      output PCWr, IRWr, NPCOp, rs_data, imem_ack, imem_rdata,
      input  imem_req, imem_addr, pc, ir, op, funct, if_stall, pc_misalign
   );

endinterface

// File: rtl/ifu_fetch_npc_calc.sv
// rtl/ifu_fetch_npc_calc.sv - combinational next-PC selection
module npc_calc
   import ifu_fetch_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] pc_i,
   input  logic [25:0]   imm26_i,
   input  logic [31:0]   rs_data_i,
   input  logic [1:0]    npc_op_i,
   output logic [AW-1:0] npc_o
);

   logic [AW-1:0] br_off;

   // Branch offset is a sign-extended word offset; pc already holds PC+4
   assign br_off = {{(AW-18){imm26_i[15]}}, imm26_i[15:0], 2'b00};

   // Select next PC; all arithmetic wraps silently
   always_comb begin
      npc_o = pc_i + AW'(4);
      case (npc_op_e'(npc_op_i))
         NPC_PC4: npc_o = pc_i + AW'(4);
         NPC_BR:  npc_o = pc_i + br_off;
         NPC_J:   npc_o = {pc_i[AW-1:28], imm26_i, 2'b00};
         NPC_JR:  npc_o = rs_data_i[AW-1:0];
         default: npc_o = pc_i + AW'(4);
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC/IR ownership, next-PC update and single-entry prefetch
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          AW       = 32
) (
   input  logic        clk,
   input  logic        reset,
   ifu_fetch_if.slave  bus
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   ir_q, ir_d;
   logic [31:0]   buf_q, buf_d;
   logic          misalign_q, misalign_d;
   logic [AW-1:0] npc;
   logic          buf_valid;
   logic          stall;
   logic          pc_acc;
   logic          ir_acc;

   // The buffer holds the instruction at pc exactly while in F_VALID
   assign buf_valid = (state_q == F_VALID);
   assign stall     = bus.IRWr & ~buf_valid;
   assign pc_acc    = bus.PCWr & ~stall;
   assign ir_acc    = bus.IRWr & buf_valid;

   npc_calc #(.AW(AW)) u_npc_calc (
      .pc_i      (pc_q),
      .imm26_i   (ir_q[25:0]),
      .rs_data_i (bus.rs_data),
      .npc_op_i  (bus.NPCOp),
      .npc_o     (npc)
   );

   // PC, IR and sticky misalignment next-state
   always_comb begin
      pc_d       = pc_acc ? npc : pc_q;
      ir_d       = ir_acc ? buf_q : ir_q;
      misalign_d = misalign_q | (pc_acc & (npc[1:0] != 2'b00));
   end

   // Fetch FSM next-state; a request is held with its address until acked
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      case (state_q)
         F_ISSUE: begin
            // A PC write in this cycle would make the issued address stale
            if (!pc_acc && (pc_q[1:0] == 2'b00)) begin
               state_d = F_WAIT;
               addr_d  = pc_q;
            end
         end
         F_WAIT: begin
            if (bus.imem_ack) begin
               if (pc_acc) begin
                  state_d = F_ISSUE;
               end else begin
                  state_d = F_VALID;
                  buf_d   = bus.imem_rdata;
               end
            end else if (pc_acc) begin
               state_d = F_FLUSH;
            end
         end
         F_FLUSH: begin
            if (bus.imem_ack) state_d = F_ISSUE;
         end
         F_VALID: begin
            if (pc_acc) state_d = F_ISSUE;
         end
         default: state_d = F_ISSUE;
      endcase
   end

   // Fetch FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= F_ISSUE;
         addr_q  <= PC_RESET[AW-1:0];
         buf_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

   // Architectural PC/IR registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= PC_RESET[AW-1:0];
         ir_q       <= 32'h0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.imem_req    = (state_q == F_WAIT) || (state_q == F_FLUSH);
   assign bus.imem_addr   = addr_q;
   assign bus.pc          = pc_q;
   assign bus.ir          = ir_q;
   assign bus.op          = ir_q[31:26];
   assign bus.funct       = ir_q[5:0];
   assign bus.if_stall    = stall;
   assign bus.pc_misalign = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   lat = 1;
   int   tests = 0;
   int   fails = 0;

   ifu_fetch_if #(.AW(32)) bus ();

   ifu_fetch #(.PC_RESET(32'h0000_3000), .AW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h3000: return 32'h3C01_1234;
         32'h3004: return 32'h1000_FFFF;
         32'h300C: return 32'h0800_0C05;
         32'h3014: return 32'h8C22_0000;
         default:  return {16'hDEAD, a[15:0]};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.PCWr    = 1'b0;
      bus.IRWr    = 1'b0;
      bus.NPCOp   = 2'b00;
      bus.rs_data = 32'h0;
   endtask

   // Hold a controller request until it is accepted, then release it
   task automatic exec(input logic irwr, input logic pcwr, input logic [1:0] npcop, input logic [31:0] rs);
      int n;
      bus.IRWr    = irwr;
      bus.PCWr    = pcwr;
      bus.NPCOp   = npcop;
      bus.rs_data = rs;
      #1;
      n = 0;
      while (bus.if_stall && n < 50) begin
         step();
         n++;
      end
      check("exec_stall_release", {31'b0, bus.if_stall}, 32'h0);
      step();
      idle();
   endtask

   // Memory responder: ack after lat request cycles (lat=1 acks in the first one)
   initial begin
      int   cnt;
      logic busy;
      busy = 1'b0;
      cnt = 0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_ack = 1'b0;
         if (!reset) begin
            busy = 1'b0;
         end else begin
            if (bus.imem_req && !busy) begin
               busy = 1'b1;
               cnt = lat;
            end
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  bus.imem_ack = 1'b1;
                  bus.imem_rdata = mem_word(bus.imem_addr);
                  busy = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   reqs;
      logic pc_ok;
      idle();
      reset = 1'b0;
      lat = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", bus.pc, 32'h3000);
      check("rst_ir", bus.ir, 32'h0);
      check("rst_req", {31'b0, bus.imem_req}, 32'h0);
      check("rst_stall", {31'b0, bus.if_stall}, 32'h0);
      check("rst_misalign", {31'b0, bus.pc_misalign}, 32'h0);

      // Minimum-latency fetch, then IRWr+PCWr
      reset = 1'b1;
      step();
      check("t1_req", {31'b0, bus.imem_req}, 32'h1);
      check("t1_addr", bus.imem_addr, 32'h3000);
      step();
      bus.IRWr = 1'b1;
      bus.PCWr = 1'b1;
      bus.NPCOp = 2'b00;
      #1;
      check("t1_nostall", {31'b0, bus.if_stall}, 32'h0);
      step();
      idle();
      check("t1_ir", bus.ir, 32'h3C01_1234);
      check("t1_op", {26'b0, bus.op}, 32'h0F);
      check("t1_funct", {26'b0, bus.funct}, 32'h34);
      check("t1_pc", bus.pc, 32'h3004);

      // Reset asserted while a request is outstanding
      lat = 10;
      step();
      check("rw_req", {31'b0, bus.imem_req}, 32'h1);
      check("rw_addr", bus.imem_addr, 32'h3004);
      #2;
      reset = 1'b0;
      #1;
      check("rw_req_drop", {31'b0, bus.imem_req}, 32'h0);
      check("rw_pc", bus.pc, 32'h3000);
      check("rw_ir", bus.ir, 32'h0);

      // Five-cycle memory latency with the controller already asking
      lat = 5;
      @(posedge clk);
      #2;
      reset = 1'b1;
      step();
      check("t2_req", {31'b0, bus.imem_req}, 32'h1);
      bus.IRWr = 1'b1;
      bus.PCWr = 1'b1;
      bus.NPCOp = 2'b00;
      #1;
      n = 0;
      pc_ok = 1'b1;
      while (bus.if_stall && n < 20) begin
         if (bus.pc !== 32'h3000) pc_ok = 1'b0;
         n++;
         step();
      end
      check("t2_stall_cycles", n, 5);
      check("t2_pc_held", {31'b0, pc_ok}, 32'h1);
      lat = 1;
      step();
      idle();
      check("t2_pc", bus.pc, 32'h3004);
      check("t2_ir", bus.ir, 32'h3C01_1234);
      step();
      check("t2_single_adv", bus.pc, 32'h3004);

      // Branch, jr and jump targets
      exec(1'b1, 1'b1, 2'b00, 32'h0);
      check("br_ir", bus.ir, 32'h1000_FFFF);
      check("br_pc_pre", bus.pc, 32'h3008);
      exec(1'b0, 1'b1, 2'b01, 32'h0);
      check("br_pc", bus.pc, 32'h3004);
      exec(1'b0, 1'b1, 2'b11, 32'h300C);
      check("jr_pc", bus.pc, 32'h300C);
      exec(1'b1, 1'b1, 2'b00, 32'h0);
      check("j_ir", bus.ir, 32'h0800_0C05);
      check("j_op", {26'b0, bus.op}, 32'h02);
      check("j_pc_pre", bus.pc, 32'h3010);
      exec(1'b0, 1'b1, 2'b10, 32'h0);
      check("j_pc", bus.pc, 32'h0000_3014);

      // Misaligned jr target blocks fetching and sets the sticky flag
      exec(1'b0, 1'b1, 2'b11, 32'h3002);
      check("mis_pc", bus.pc, 32'h3002);
      check("mis_flag", {31'b0, bus.pc_misalign}, 32'h1);
      reqs = 0;
      repeat (4) begin
         if (bus.imem_req) reqs++;
         step();
      end
      check("mis_no_req", reqs, 0);
      exec(1'b0, 1'b1, 2'b11, 32'h3000);
      check("mis_sticky", {31'b0, bus.pc_misalign}, 32'h1);

      // PC write while a fetch is outstanding: stale data must be dropped
      reset = 1'b0;
      step();
      check("fl_rst_misalign", {31'b0, bus.pc_misalign}, 32'h0);
      lat = 4;
      reset = 1'b1;
      step();
      check("fl_addr0", bus.imem_addr, 32'h3000);
      step();
      exec(1'b0, 1'b1, 2'b11, 32'h3014);
      check("fl_pc", bus.pc, 32'h3014);
      check("fl_req_held", {31'b0, bus.imem_req}, 32'h1);
      check("fl_addr_held", bus.imem_addr, 32'h3000);
      n = 0;
      while (!(bus.imem_req && bus.imem_addr == 32'h3014) && n < 20) begin
         step();
         n++;
      end
      check("fl_reissue_delay", n, 3);
      check("fl_ir_untouched", bus.ir, 32'h0);
      exec(1'b1, 1'b1, 2'b00, 32'h0);
      check("fl_ir_new", bus.ir, 32'h8C22_0000);
      check("fl_pc_new", bus.pc, 32'h3018);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch unit for the multicycle MIPS core.
- Sits directly upstream of the FSM controller. It consumes the controller's PCWr, IRWr and NPCOp, and produces the op/funct fields the controller decodes.
- Owns the PC and IR, computes next PC, and prefetches from an instruction memory with a variable-latency req/ack handshake.
- Reports if_stall; the controller holds state S0 while if_stall=1.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- AW, 32, PC / imem address width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCWr  in  1  PC write enable from controller.
- IRWr  in  1  IR load enable from controller.
- NPCOp  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- rs_data  in  32  register rs value, jr target.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch word address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- pc  out  AW  current PC.
- ir  out  32  instruction register.
- op  out  6  ir[31:26].
- funct  out  6  ir[5:0].
- if_stall  out  1  IRWr requested but buffer not valid.
- pc_misalign  out  1  sticky: a PC with pc[1:0]!=0 was loaded.

Behaviour:
- Reset (reset=0, async), outputs and state:
  - pc=PC_RESET, ir=0, imem_req=0, if_stall=0, pc_misalign=0.
  - Fetch buffer invalid; fetch FSM in F_ISSUE.
- Next-PC, used on an accepted PC write:
  - 00: pc+4.
  - 01: pc + (sign-extended ir[15:0] << 2). pc already holds PC+4 at this point.
  - 10: {pc[31:28], ir[25:0], 2'b00}.
  - 11: rs_data.
  - All arithmetic is 32-bit modulo; wrap at 32'hFFFF_FFFC is silent.
- Stall gating:
  - if_stall = IRWr & !buf_valid.
  - While if_stall=1, both IRWr and PCWr are ignored: no IR load, no PC change.
- IRWr accepted (buf_valid=1): ir <= buffer next edge.
- PCWr accepted:
  - pc <= next-PC next edge.
  - Buffer invalidated in the same edge.
  - If pc[1:0] of the new value != 0, pc_misalign <= 1.
- IRWr and PCWr in the same cycle (controller S0):
  - IR takes the buffer for the old pc.
  - PC advances.
  - Both happen on the same edge.
- Fetch FSM:
  - F_ISSUE:
    - If pc[1:0]==0 and buffer invalid, assert imem_req with imem_addr=pc and go to F_WAIT.
    - If misaligned, stay in F_ISSUE with imem_req=0.
  - F_WAIT:
    - imem_req=1, imem_addr held.
    - On imem_ack: capture imem_rdata, buf_valid<=1, imem_req<=0, go to F_VALID.
    - If an accepted PCWr coincides with imem_ack: discard the data, go to F_ISSUE.
    - If an accepted PCWr occurs without imem_ack: go to F_FLUSH.
  - F_FLUSH:
    - Stale request still outstanding; imem_req=1 with the old address.
    - On imem_ack: discard data, go to F_ISSUE.
    - Further PCWr: stay in F_FLUSH.
  - F_VALID:
    - Buffer holds the instruction at pc.
    - On an accepted PCWr: buf_valid<=0, go to F_ISSUE.
- Fetch timing:
  - Minimum fetch latency: 1 cycle in F_ISSUE, then imem_ack in the first F_WAIT cycle, so the buffer is valid 2 cycles after a PC write.
  - imem_ack outside F_WAIT/F_FLUSH is ignored.
- op and funct are combinational slices of ir.

Decomposition:
- Shared package/header gains:
  - NPC_PC4, NPC_BR, NPC_J, NPC_JR codes (2'b00..2'b11).
  - Fetch FSM state codes F_ISSUE, F_WAIT, F_FLUSH, F_VALID.
  - PC_RESET default.
- One sub-module, npc_calc: combinational next-PC mux/adder, instantiated once.

Test Plan:
- Reset, then memory acks 1 cycle after req with 32'h3C01_1234 -> imem_addr=32'h3000; 2 cycles later buf_valid; IRWr+PCWr(NPCOp=00) -> ir=32'h3C01_1234, op=6'h0F, pc=32'h3004.
- Memory ack delayed 5 cycles; controller asserts IRWr+PCWr from cycle 1 -> if_stall=1 for 5 cycles, pc stays 32'h3000, then single advance to 32'h3004.
- ir=beq with imm16=16'hFFFF, pc=32'h3008, PCWr NPCOp=01 -> pc=32'h3004. J with ir[25:0]=26'h0000C05, pc=32'h3010 -> pc=32'h0000_3014.
- PCWr NPCOp=11 with rs_data=32'h3002 -> pc=32'h3002, pc_misalign=1 (stays 1), imem_req stays 0.
- PCWr during F_WAIT (ack pending 3 cycles) -> stale ack data not loaded; new request at new pc issued the cycle after the stale ack; ir equals the new-address data.
- Assert reset mid-F_WAIT -> imem_req drops immediately, pc=32'h3000, ir=0.
